// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory-stage access controller.
package mem_ctrl_pkg;

  localparam int MEM_DEPTH_DEF = 1000;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WR_SETUP   = 3'd1,
    WR_STROBE  = 3'd2,
    WR_HOLD    = 3'd3,
    RD_SETUP   = 3'd4,
    RD_STROBE  = 3'd5,
    RD_CAPTURE = 3'd6,
    RESP       = 3'd7
  } state_t;

endpackage

// File: rtl/mem_access_ctrl.sv
// Memory-stage sequencer: one load/store at a time, with setup/strobe/hold
// phasing on the data_mem strobes and a range-checked response to writeback.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int RD_W      = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [RD_W-1:0]   req_rd,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [RD_W-1:0]   resp_rd,
  output logic              resp_fault,
  output logic              MemW,
  output logic              MemR,
  output logic [DATA_W-1:0] MemIn,
  output logic [ADDR_W-1:0] WriteAddr,
  input  logic [DATA_W-1:0] MemOut
);

  // One extra bit so a depth of exactly 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);

  state_t            state, next_state;
  logic              accept;
  logic              addr_fault;
  logic [RD_W-1:0]   rd_q;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign accept     = req_valid & req_ready;
  assign addr_fault = ({1'b0, req_addr} >= DEPTH_L);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: default assigned first so no path through the case leaves
  // next_state unassigned, which would infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (addr_fault)  next_state = RESP;
          else if (req_we) next_state = WR_SETUP;
          else             next_state = RD_SETUP;
        end
      end
      WR_SETUP:   next_state = WR_STROBE;
      WR_STROBE:  next_state = WR_HOLD;
      WR_HOLD:    next_state = RESP;
      RD_SETUP:   next_state = RD_STROBE;
      RD_STROBE:  next_state = RD_CAPTURE;
      RD_CAPTURE: next_state = RESP;
      RESP:       next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  // Strobes are decoded from next_state so they are flop outputs aligned to
  // the state they belong to. Address/data are loaded only at accept, which
  // keeps them stable from setup through hold/capture by construction.
  // NOTE: async reset on these flops makes the strobes fall the moment
  // rst_n asserts, without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      MemW       <= 1'b0;
      MemR       <= 1'b0;
      MemIn      <= '0;
      WriteAddr  <= '0;
      rd_q       <= '0;
      resp_rdata <= '0;
      resp_rd    <= '0;
      resp_fault <= 1'b0;
    end else begin
      MemW <= (next_state == WR_STROBE);
      MemR <= (next_state == RD_STROBE) || (next_state == RD_CAPTURE);

      if (accept && !addr_fault) begin
        rd_q <= req_rd;
        if (req_we) begin
          WriteAddr <= req_addr;
          MemIn     <= req_wdata;
        end else begin
          MemIn     <= DATA_W'(req_addr);
        end
      end

      // Response fields change only on entry to RESP and then hold.
      if (next_state == RESP) begin
        resp_fault <= (state == IDLE);
        resp_rd    <= (state == IDLE) ? req_rd : rd_q;
        resp_rdata <= (state == RD_CAPTURE) ? MemOut : '0;
      end
    end
  end

endmodule
